// File: rtl/snake_move_scheduler.sv
// -----------------------------------------------------------------------------
// snake_move_scheduler
//
// Sequences the snake datapath. Runs the game FSM (IDLE/RUN/PAUSE/DEAD),
// merges key and IR turn requests through a 2-entry turn queue that rejects
// reversals, emits a one-cycle move_en step strobe together with the
// direction to apply, and shortens the step period as the score rises.
//
// Ports
//   game_clk      in   1   system clock
//   sys_rst       in   1   synchronous reset, active-high
//   kf_right      in   1   debounced key pulse (highest key priority)
//   kf_left       in   1   debounced key pulse
//   kf_up         in   1   debounced key pulse
//   kf_down       in   1   debounced key pulse (lowest key priority)
//   ir_valid      in   1   one-cycle strobe, ir_code valid
//   ir_code       in   8   NEC command: 43 R, 44 L, 46 U, 15 D, 40 pause toggle
//   die           in   1   collision from datapath, level-sensitive
//   score         in   20  current score, unsigned
//   move_en       out  1   one-cycle step strobe
//   dir           out  2   direction for this step: 00 L, 01 R, 10 D, 11 U
//   restart       out  1   one-cycle pulse asking the datapath to reload
//   game_state    out  2   00 IDLE, 01 RUN, 10 PAUSE, 11 DEAD
//   speed_level   out  4   0..15
// -----------------------------------------------------------------------------
module snake_move_scheduler #(
   parameter int TICK_BASE       = 12_500_000,
   parameter int TICK_STEP       = 1_250_000,
   parameter int TICK_MIN        = 2_500_000,
   parameter int SCORE_PER_LEVEL = 100
) (
   input  logic        game_clk,
   input  logic        sys_rst,
   input  logic        kf_right,
   input  logic        kf_left,
   input  logic        kf_up,
   input  logic        kf_down,
   input  logic        ir_valid,
   input  logic [7:0]  ir_code,
   input  logic        die,
   input  logic [19:0] score,
   output logic        move_en,
   output logic [1:0]  dir,
   output logic        restart,
   output logic [1:0]  game_state,
   output logic [3:0]  speed_level
);

   localparam int CW = $clog2(TICK_BASE + 1);

   localparam logic [1:0] DIR_L = 2'b00;
   localparam logic [1:0] DIR_R = 2'b01;
   localparam logic [1:0] DIR_D = 2'b10;
   localparam logic [1:0] DIR_U = 2'b11;

   localparam logic [CW-1:0] BASE_P = CW'(TICK_BASE);
   localparam logic [CW-1:0] MIN_P  = CW'(TICK_MIN);
   localparam logic [31:0]   SPAN   = 32'(TICK_BASE - TICK_MIN);
   localparam logic [20:0]   SPL    = 21'(SCORE_PER_LEVEL);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_DEAD  = 2'b11
   } state_t;

   state_t          state_reg,  state_next;
   logic [1:0]      dir_reg,    dir_next;
   logic            move_en_reg, move_en_next;
   logic            restart_reg, restart_next;
   logic [3:0]      level_reg,  level_next;
   logic [20:0]     thresh_reg, thresh_next;
   logic [CW-1:0]   period_reg, period_next;
   logic [CW-1:0]   cnt_reg,    cnt_next;
   logic [1:0]      q_reg  [2];
   logic [1:0]      q_next [2];
   logic [1:0]      q_cnt_reg,  q_cnt_next;

   // ---------------------------------------------------------------------
   // Request arbitration: one request per cycle, keys before IR,
   // keys ordered R > L > U > D. The pause toggle is an IR request and
   // therefore loses to any key pressed in the same cycle.
   // ---------------------------------------------------------------------
   logic       req_valid;
   logic [1:0] req_dir;
   logic       pause_req;

   always_comb begin
      req_valid = 1'b0;
      req_dir   = DIR_R;
      pause_req = 1'b0;
      if (kf_right) begin
         req_valid = 1'b1;
         req_dir   = DIR_R;
      end else if (kf_left) begin
         req_valid = 1'b1;
         req_dir   = DIR_L;
      end else if (kf_up) begin
         req_valid = 1'b1;
         req_dir   = DIR_U;
      end else if (kf_down) begin
         req_valid = 1'b1;
         req_dir   = DIR_D;
      end else if (ir_valid) begin
         case (ir_code)
            8'h43:   begin req_valid = 1'b1; req_dir = DIR_R; end
            8'h44:   begin req_valid = 1'b1; req_dir = DIR_L; end
            8'h46:   begin req_valid = 1'b1; req_dir = DIR_U; end
            8'h15:   begin req_valid = 1'b1; req_dir = DIR_D; end
            8'h40:   pause_req = 1'b1;
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Turn queue acceptance. The reference direction is the most recently
   // queued turn (or the current direction when empty). Directions that
   // share bit 1 are either equal or opposite, both of which are dropped.
   // ---------------------------------------------------------------------
   logic [1:0] q_tail;
   logic [1:0] ref_dir;
   logic       accept;

   assign q_tail  = (q_cnt_reg == 2'd2) ? q_reg[1] : q_reg[0];
   assign ref_dir = (q_cnt_reg != 2'd0) ? q_tail : dir_reg;
   assign accept  = req_valid && (req_dir[1] != ref_dir[1]) && (q_cnt_reg != 2'd2);

   // ---------------------------------------------------------------------
   // Step period for the current level, clamped at TICK_MIN without
   // ever forming a negative intermediate.
   // ---------------------------------------------------------------------
   logic [31:0]   level_red;
   logic [CW-1:0] period_calc;

   assign level_red   = 32'(level_reg) * 32'(TICK_STEP);
   assign period_calc = (level_red >= SPAN) ? MIN_P : CW'(32'(TICK_BASE) - level_red);

   // ---------------------------------------------------------------------
   // Next-state and output logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_next   = state_reg;
      dir_next     = dir_reg;
      move_en_next = 1'b0;
      restart_next = 1'b0;
      level_next   = level_reg;
      thresh_next  = thresh_reg;
      period_next  = period_reg;
      cnt_next     = cnt_reg;
      q_next       = q_reg;
      q_cnt_next   = q_cnt_reg;

      case (state_reg)
         ST_IDLE: begin
            if (req_valid) begin
               state_next = ST_RUN;
               dir_next   = req_dir;
               q_cnt_next = 2'd0;
               cnt_next   = '0;
            end
         end

         ST_RUN: begin
            if (die) begin
               // Collision wins over both a same-cycle step and pause.
               state_next = ST_DEAD;
            end else begin
               if (pause_req) begin
                  // Counter is held on the pause cycle so the remaining
                  // step time is preserved exactly across the pause.
                  state_next = ST_PAUSE;
               end else if (cnt_reg == period_reg - CW'(1)) begin
                  cnt_next     = '0;
                  period_next  = period_calc;
                  move_en_next = 1'b1;
                  if (q_cnt_reg != 2'd0) begin
                     dir_next   = q_reg[0];
                     q_next[0]  = q_reg[1];
                     q_cnt_next = q_cnt_reg - 2'd1;
                  end
               end else begin
                  cnt_next = cnt_reg + CW'(1);
               end

               // Enqueue after any pop; acceptance was judged on the
               // pre-pop queue contents.
               if (accept) begin
                  q_next[q_cnt_next[0]] = req_dir;
                  q_cnt_next            = q_cnt_next + 2'd1;
               end

               if (({1'b0, score} >= thresh_reg) && (level_reg != 4'd15)) begin
                  level_next  = level_reg + 4'd1;
                  thresh_next = thresh_reg + SPL;
               end
            end
         end

         ST_PAUSE: begin
            if (pause_req) begin
               state_next = ST_RUN;
            end
         end

         ST_DEAD: begin
            // The waking request is consumed; the game waits in IDLE
            // for a fresh request to start.
            if (req_valid) begin
               state_next   = ST_IDLE;
               restart_next = 1'b1;
               q_cnt_next   = 2'd0;
               dir_next     = DIR_R;
               level_next   = 4'd0;
               thresh_next  = SPL;
               period_next  = BASE_P;
               cnt_next     = '0;
            end
         end

         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge game_clk) begin
      if (sys_rst) begin
         state_reg   <= ST_IDLE;
         dir_reg     <= DIR_R;
         move_en_reg <= 1'b0;
         restart_reg <= 1'b0;
         level_reg   <= 4'd0;
         thresh_reg  <= SPL;
         period_reg  <= BASE_P;
         cnt_reg     <= '0;
         q_reg[0]    <= DIR_R;
         q_reg[1]    <= DIR_R;
         q_cnt_reg   <= 2'd0;
      end else begin
         state_reg   <= state_next;
         dir_reg     <= dir_next;
         move_en_reg <= move_en_next;
         restart_reg <= restart_next;
         level_reg   <= level_next;
         thresh_reg  <= thresh_next;
         period_reg  <= period_next;
         cnt_reg     <= cnt_next;
         q_reg[0]    <= q_next[0];
         q_reg[1]    <= q_next[1];
         q_cnt_reg   <= q_cnt_next;
      end
   end

   assign move_en     = move_en_reg;
   assign dir         = dir_reg;
   assign restart     = restart_reg;
   assign game_state  = state_reg;
   assign speed_level = level_reg;

endmodule

// File: tb/tb_snake_move_scheduler.sv
// -----------------------------------------------------------------------------
// tb_snake_move_scheduler
//
// Directed bench for snake_move_scheduler with small tick parameters
// (base 10, step 2, min 4, 20 points per level). Inputs change just after
// the falling edge and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_snake_move_scheduler;

   logic        game_clk;
   logic        sys_rst;
   logic        kf_right, kf_left, kf_up, kf_down;
   logic        ir_valid;
   logic [7:0]  ir_code;
   logic        die;
   logic [19:0] score;
   logic        move_en;
   logic [1:0]  dir;
   logic        restart;
   logic [1:0]  game_state;
   logic [3:0]  speed_level;

   int errors = 0;
   int checks = 0;

   snake_move_scheduler #(
      .TICK_BASE       (10),
      .TICK_STEP       (2),
      .TICK_MIN        (4),
      .SCORE_PER_LEVEL (20)
   ) dut (
      .game_clk    (game_clk),
      .sys_rst     (sys_rst),
      .kf_right    (kf_right),
      .kf_left     (kf_left),
      .kf_up       (kf_up),
      .kf_down     (kf_down),
      .ir_valid    (ir_valid),
      .ir_code     (ir_code),
      .die         (die),
      .score       (score),
      .move_en     (move_en),
      .dir         (dir),
      .restart     (restart),
      .game_state  (game_state),
      .speed_level (speed_level)
   );

   initial begin
      game_clk = 1'b0;
      forever #5 game_clk = ~game_clk;
   end

   // One-cycle stimulus pulse: k = {right,left,up,down}
   task automatic drive(input logic [3:0] k, input logic iv, input logic [7:0] code);
      {kf_right, kf_left, kf_up, kf_down} = k;
      ir_valid = iv;
      ir_code  = code;
      @(negedge game_clk);
      {kf_right, kf_left, kf_up, kf_down} = 4'b0000;
      ir_valid = 1'b0;
      ir_code  = 8'h00;
   endtask

   task automatic do_reset();
      sys_rst = 1'b1;
      @(negedge game_clk);
      sys_rst = 1'b0;
   endtask

   // Counts falling edges until move_en is seen, bounded at 200
   task automatic wait_step(output int n);
      n = 0;
      do begin
         @(negedge game_clk);
         n++;
      end while (move_en !== 1'b1 && n < 200);
   endtask

   task automatic test_reset();
      sys_rst = 1'b1;
      repeat (3) @(negedge game_clk);
      sys_rst = 1'b0;
      checks++; if (game_state !== 2'b00) begin errors++; $display("FAIL reset_state got=%0d want=0", game_state); end
      checks++; if (dir !== 2'b01) begin errors++; $display("FAIL reset_dir got=%0d want=1", dir); end
      checks++; if (move_en !== 1'b0) begin errors++; $display("FAIL reset_move_en got=%b want=0", move_en); end
      checks++; if (restart !== 1'b0) begin errors++; $display("FAIL reset_restart got=%b want=0", restart); end
      checks++; if (speed_level !== 4'd0) begin errors++; $display("FAIL reset_level got=%0d want=0", speed_level); end
      $display("test_reset done");
   endtask

   task automatic test_start();
      int n;
      drive(4'b0010, 1'b0, 8'h00);
      checks++; if (game_state !== 2'b01) begin errors++; $display("FAIL start_state got=%0d want=1", game_state); end
      checks++; if (dir !== 2'b11) begin errors++; $display("FAIL start_dir got=%0d want=3", dir); end
      checks++; if (move_en !== 1'b0) begin errors++; $display("FAIL start_move_en got=%b want=0", move_en); end
      wait_step(n);
      checks++; if (n != 10) begin errors++; $display("FAIL start_latency got=%0d want=10", n); end
      checks++; if (dir !== 2'b11) begin errors++; $display("FAIL start_step_dir got=%0d want=3", dir); end
      @(negedge game_clk);
      checks++; if (move_en !== 1'b0) begin errors++; $display("FAIL start_strobe_width got=%b want=0", move_en); end
      wait_step(n);
      checks++; if (n != 9) begin errors++; $display("FAIL start_second_step got=%0d want=9", n); end
      $display("test_start done");
   endtask

   task automatic test_reversal();
      int n;
      int exp_n [3] = '{6, 10, 10};
      logic [1:0] exp_d [3] = '{2'b11, 2'b00, 2'b00};
      do_reset();
      drive(4'b1000, 1'b0, 8'h00);
      checks++; if (dir !== 2'b01) begin errors++; $display("FAIL rev_start_dir got=%0d want=1", dir); end
      drive(4'b0100, 1'b0, 8'h00);   // reversal, dropped
      drive(4'b0010, 1'b0, 8'h00);   // U queued
      drive(4'b0000, 1'b1, 8'h44);   // L queued
      drive(4'b0001, 1'b0, 8'h00);   // D dropped, queue full
      for (int i = 0; i < 3; i++) begin
         wait_step(n);
         checks++; if (n != exp_n[i]) begin errors++; $display("FAIL rev_step%0d_time got=%0d want=%0d", i, n, exp_n[i]); end
         checks++; if (dir !== exp_d[i]) begin errors++; $display("FAIL rev_step%0d_dir got=%0d want=%0d", i, dir, exp_d[i]); end
      end
      $display("test_reversal done");
   endtask

   task automatic test_arbitration();
      int n;
      do_reset();
      drive(4'b0110, 1'b0, 8'h00);   // L beats U
      checks++; if (dir !== 2'b00) begin errors++; $display("FAIL arb_key_prio got=%0d want=0", dir); end
      drive(4'b0001, 1'b1, 8'h46);   // key D beats IR U
      wait_step(n);
      checks++; if (n != 9) begin errors++; $display("FAIL arb_step0_time got=%0d want=9", n); end
      checks++; if (dir !== 2'b10) begin errors++; $display("FAIL arb_step0_dir got=%0d want=2", dir); end
      wait_step(n);
      checks++; if (n != 10) begin errors++; $display("FAIL arb_step1_time got=%0d want=10", n); end
      checks++; if (dir !== 2'b10) begin errors++; $display("FAIL arb_step1_dir got=%0d want=2", dir); end
      $display("test_arbitration done");
   endtask

   task automatic test_die_step();
      do_reset();
      drive(4'b1000, 1'b0, 8'h00);
      repeat (9) @(negedge game_clk);
      die = 1'b1;
      @(negedge game_clk);
      checks++; if (move_en !== 1'b0) begin errors++; $display("FAIL die_step_move_en got=%b want=0", move_en); end
      checks++; if (game_state !== 2'b11) begin errors++; $display("FAIL die_step_state got=%0d want=3", game_state); end
      drive(4'b0000, 1'b1, 8'h40);
      checks++; if (game_state !== 2'b11) begin errors++; $display("FAIL dead_pause_state got=%0d want=3", game_state); end
      checks++; if (move_en !== 1'b0) begin errors++; $display("FAIL dead_move_en got=%b want=0", move_en); end
      die = 1'b0;
      $display("test_die_step done");
   endtask

   task automatic test_speed_burst();
      int exp_lv [4] = '{1, 2, 3, 3};
      do_reset();
      score = 20'd0;
      drive(4'b0010, 1'b0, 8'h00);
      score = 20'd60;
      for (int i = 0; i < 4; i++) begin
         @(negedge game_clk);
         checks++; if (speed_level !== 4'(exp_lv[i])) begin errors++; $display("FAIL burst_level%0d got=%0d want=%0d", i, speed_level, exp_lv[i]); end
      end
      die = 1'b1;
      @(negedge game_clk);
      die = 1'b0;
      checks++; if (game_state !== 2'b11) begin errors++; $display("FAIL burst_dead got=%0d want=3", game_state); end
      $display("test_speed_burst done");
   endtask

   task automatic test_restart();
      score = 20'd0;
      drive(4'b1000, 1'b0, 8'h00);
      checks++; if (restart !== 1'b1) begin errors++; $display("FAIL restart_pulse got=%b want=1", restart); end
      checks++; if (game_state !== 2'b00) begin errors++; $display("FAIL restart_state got=%0d want=0", game_state); end
      checks++; if (dir !== 2'b01) begin errors++; $display("FAIL restart_dir got=%0d want=1", dir); end
      checks++; if (speed_level !== 4'd0) begin errors++; $display("FAIL restart_level got=%0d want=0", speed_level); end
      @(negedge game_clk);
      checks++; if (restart !== 1'b0) begin errors++; $display("FAIL restart_width got=%b want=0", restart); end
      checks++; if (game_state !== 2'b00) begin errors++; $display("FAIL restart_no_run got=%0d want=0", game_state); end
      checks++; if (move_en !== 1'b0) begin errors++; $display("FAIL restart_move_en got=%b want=0", move_en); end
      $display("test_restart done");
   endtask

   task automatic test_speed_period();
      int n;
      int exp_n  [5] = '{10, 8, 6, 4, 4};
      int exp_lv [5] = '{1, 2, 3, 4, 4};
      int nxt_sc [5] = '{40, 60, 80, 80, 80};
      do_reset();
      score = 20'd0;
      drive(4'b1000, 1'b0, 8'h00);
      score = 20'd20;
      for (int i = 0; i < 5; i++) begin
         wait_step(n);
         checks++; if (n != exp_n[i]) begin errors++; $display("FAIL period%0d got=%0d want=%0d", i, n, exp_n[i]); end
         checks++; if (speed_level !== 4'(exp_lv[i])) begin errors++; $display("FAIL period%0d_level got=%0d want=%0d", i, speed_level, exp_lv[i]); end
         score = 20'(nxt_sc[i]);
      end
      score = 20'd0;
      $display("test_speed_period done");
   endtask

   task automatic test_pause();
      int n;
      do_reset();
      score = 20'd0;
      drive(4'b1000, 1'b0, 8'h00);
      repeat (5) @(negedge game_clk);
      drive(4'b0000, 1'b1, 8'h40);
      checks++; if (game_state !== 2'b10) begin errors++; $display("FAIL pause_enter got=%0d want=2", game_state); end
      for (int i = 0; i < 20; i++) begin
         if (i == 3) kf_up = 1'b1;
         if (i == 8) die = 1'b1;
         @(negedge game_clk);
         kf_up = 1'b0;
         die   = 1'b0;
         checks++; if (move_en !== 1'b0) begin errors++; $display("FAIL pause_move_en cyc=%0d got=%b want=0", i, move_en); end
         checks++; if (game_state !== 2'b10) begin errors++; $display("FAIL pause_hold cyc=%0d got=%0d want=2", i, game_state); end
      end
      drive(4'b0000, 1'b1, 8'h40);
      checks++; if (game_state !== 2'b01) begin errors++; $display("FAIL pause_resume got=%0d want=1", game_state); end
      wait_step(n);
      checks++; if (n != 5) begin errors++; $display("FAIL pause_remaining got=%0d want=5", n); end
      checks++; if (dir !== 2'b01) begin errors++; $display("FAIL pause_dir got=%0d want=1", dir); end
      $display("test_pause done");
   endtask

   task automatic test_reset_midrun();
      int n;
      do_reset();
      drive(4'b0010, 1'b0, 8'h00);
      score = 20'd20;
      drive(4'b0100, 1'b0, 8'h00);
      repeat (8) @(negedge game_clk);
      sys_rst = 1'b1;
      @(negedge game_clk);
      sys_rst = 1'b0;
      score   = 20'd0;
      checks++; if (move_en !== 1'b0) begin errors++; $display("FAIL midrst_move_en got=%b want=0", move_en); end
      checks++; if (game_state !== 2'b00) begin errors++; $display("FAIL midrst_state got=%0d want=0", game_state); end
      checks++; if (dir !== 2'b01) begin errors++; $display("FAIL midrst_dir got=%0d want=1", dir); end
      checks++; if (speed_level !== 4'd0) begin errors++; $display("FAIL midrst_level got=%0d want=0", speed_level); end
      checks++; if (restart !== 1'b0) begin errors++; $display("FAIL midrst_restart got=%b want=0", restart); end
      drive(4'b1000, 1'b0, 8'h00);
      wait_step(n);
      checks++; if (n != 10) begin errors++; $display("FAIL midrst_step_time got=%0d want=10", n); end
      checks++; if (dir !== 2'b01) begin errors++; $display("FAIL midrst_queue_cleared got=%0d want=1", dir); end
      $display("test_reset_midrun done");
   endtask

   initial begin
      sys_rst  = 1'b1;
      {kf_right, kf_left, kf_up, kf_down} = 4'b0000;
      ir_valid = 1'b0;
      ir_code  = 8'h00;
      die      = 1'b0;
      score    = 20'd0;
      @(negedge game_clk);
      test_reset();
      test_start();
      test_reversal();
      test_arbitration();
      test_die_step();
      test_speed_burst();
      test_restart();
      test_speed_period();
      test_pause();
      test_reset_midrun();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
